// File: rtl/irq_controller_if.sv
// Register-access bus between the device mux (master) and the interrupt controller (slave).
interface irq_controller_if;
  logic [15:0] data_write;
  logic [15:0] data_read;
  logic [7:0]  addr;
  logic        uds;
  logic        lds;
  logic        rw;
  logic        ack;

  modport master (
    output data_write, addr, uds, lds, rw,
    input  data_read, ack
  );

  modport slave (
    input  data_write, addr, uds, lds, rw,
    output data_read, ack
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: synchronises and latches peripheral requests, masks them and drives ipl_n.
// Optional per-source level sensitivity (MODE register at 0x06) is built with `define IRQ_LEVEL_MODE_EN.
module irq_controller #(
  parameter int NUM_SRC = 7
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq,
  irq_controller_if.slave    bus,
  output logic [2:0]         ipl_n
);

  localparam logic [6:0] ADDR_PENDING = 7'h00;
  localparam logic [6:0] ADDR_ENABLE  = 7'h01;
  localparam logic [6:0] ADDR_CTRL    = 7'h02;
  localparam logic [6:0] ADDR_MODE    = 7'h03;

  typedef enum logic {
    IDLE,
    DONE
  } bus_state_t;

  bus_state_t state_reg, state_next;

  logic [NUM_SRC-1:0] sync1_reg, sync2_reg, sync2_d_reg;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_reg, pending_next;
  logic [NUM_SRC-1:0] pending_eff;
  logic [NUM_SRC-1:0] enable_reg, enable_next;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] active;
  logic               gie_reg, gie_next;
  logic               ack_reg, ack_next;
  logic [15:0]        data_read_reg, data_read_next;
  logic [15:0]        read_word;
  logic [15:0]        lane_mask;
  logic [2:0]         ipl_n_reg;
  logic [2:0]         lvl;
  logic [6:0]         word_addr;
  logic               strobe;
  logic               do_access;
  logic               do_write;
  logic               do_read;
  logic               unused_addr_lsb;

`ifdef IRQ_LEVEL_MODE_EN
  logic [NUM_SRC-1:0] mode_reg, mode_next;
`endif

  assign strobe          = bus.uds | bus.lds;
  assign word_addr       = bus.addr[7:1];
  assign unused_addr_lsb = bus.addr[0];
  assign lane_mask       = {{8{bus.uds}}, {8{bus.lds}}};
  assign do_access       = (state_reg == IDLE) && strobe;
  assign do_write        = do_access && !bus.rw;
  assign do_read         = do_access && bus.rw;

  // Rising-edge detect on the synchronised request, one bit per source.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_edge
      assign rise[gi] = sync2_reg[gi] & ~sync2_d_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      sync2_d_reg <= '0;
    end else begin
      sync1_reg   <= irq;
      sync2_reg   <= sync1_reg;
      sync2_d_reg <= sync2_reg;
    end
  end

  // Level-sensitive sources follow the synchronised input directly, not the latch.
`ifdef IRQ_LEVEL_MODE_EN
  assign pending_eff = (pending_reg & ~mode_reg) | (sync2_reg & mode_reg);
`else
  assign pending_eff = pending_reg;
`endif

  always_comb begin
    enable_next = enable_reg;
    gie_next    = gie_reg;
    clr         = '0;
`ifdef IRQ_LEVEL_MODE_EN
    mode_next   = mode_reg;
`endif
    if (do_write) begin
      case (word_addr)
        ADDR_PENDING: clr = NUM_SRC'(bus.data_write & lane_mask);
        ADDR_ENABLE:  enable_next = NUM_SRC'((16'(enable_reg) & ~lane_mask) |
                                             (bus.data_write & lane_mask));
        ADDR_CTRL:    if (bus.lds) gie_next = bus.data_write[0];
`ifdef IRQ_LEVEL_MODE_EN
        ADDR_MODE:    mode_next = NUM_SRC'((16'(mode_reg) & ~lane_mask) |
                                           (bus.data_write & lane_mask));
`endif
        default: ;
      endcase
    end
    // A new edge on the same bit as a clear wins, so the request is never lost.
    pending_next = (pending_reg & ~clr) | rise;
`ifdef IRQ_LEVEL_MODE_EN
    pending_next = (pending_next & ~mode_reg) | (sync2_reg & mode_reg);
`endif
  end

  assign active = pending_eff & enable_reg & {NUM_SRC{gie_reg}};

  always_comb begin
    lvl = 3'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active[i]) lvl = 3'(i + 1);
    end
  end

  always_comb begin
    read_word = 16'h0000;
    case (word_addr)
      ADDR_PENDING: read_word = 16'(pending_eff);
      ADDR_ENABLE:  read_word = 16'(enable_reg);
      ADDR_CTRL:    read_word = {5'b0, lvl, 7'b0, gie_reg};
`ifdef IRQ_LEVEL_MODE_EN
      ADDR_MODE:    read_word = 16'(mode_reg);
`endif
      default:      read_word = 16'h0000;
    endcase
  end

  always_comb begin
    state_next     = state_reg;
    ack_next       = 1'b0;
    data_read_next = data_read_reg;
    case (state_reg)
      IDLE: begin
        if (strobe) begin
          ack_next   = 1'b1;
          state_next = DONE;
          if (do_read) data_read_next = read_word;
        end
      end
      DONE: begin
        if (!strobe) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      ack_reg       <= 1'b0;
      data_read_reg <= 16'h0000;
      pending_reg   <= '0;
      enable_reg    <= '0;
      gie_reg       <= 1'b0;
      ipl_n_reg     <= 3'b111;
`ifdef IRQ_LEVEL_MODE_EN
      mode_reg      <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      ack_reg       <= ack_next;
      data_read_reg <= data_read_next;
      pending_reg   <= pending_next;
      enable_reg    <= enable_next;
      gie_reg       <= gie_next;
      ipl_n_reg     <= ~lvl;
`ifdef IRQ_LEVEL_MODE_EN
      mode_reg      <= mode_next;
`endif
    end
  end

  assign bus.ack       = ack_reg;
  assign bus.data_read = data_read_reg;
  assign ipl_n         = ipl_n_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register access, priority encoding, W1C races and bus handshake.
module tb_irq_controller;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] irq;
  logic [2:0] ipl_n;
  int         vectors = 0;
  int         miscompares = 0;
  int         ack_cnt;
  logic [15:0] rd;

  irq_controller_if bus_if ();

  irq_controller #(.NUM_SRC(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq),
    .bus     (bus_if.slave),
    .ipl_n   (ipl_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives the strobe immediately and returns one negedge after ack drops.
  task automatic bus_xfer(input logic is_read, input logic [7:0] a, input logic [15:0] d,
                          input logic u, input logic l, output logic [15:0] data);
    int n;
    bus_if.addr       = a;
    bus_if.data_write = d;
    bus_if.rw         = is_read;
    bus_if.uds        = u;
    bus_if.lds        = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_if.ack !== 1'b1 && n < 10);
    check("ack_rise", 16'(bus_if.ack), 16'h0001);
    data = bus_if.data_read;
    bus_if.uds = 1'b0;
    bus_if.lds = 1'b0;
    bus_if.rw  = 1'b1;
    @(negedge clk);
    check("ack_single", 16'(bus_if.ack), 16'h0000);
    $display("%s addr=%02h data=%04h uds=%b lds=%b ipl_n=%b",
             is_read ? "RD" : "WR", a, is_read ? data : d, u, l, ipl_n);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic u, input logic l);
    logic [15:0] dummy;
    bus_xfer(1'b0, a, d, u, l, dummy);
  endtask

  task automatic rd_check(input string tag, input logic [7:0] a, input logic [15:0] exp);
    logic [15:0] v;
    bus_xfer(1'b1, a, 16'h0000, 1'b1, 1'b1, v);
    check(tag, v, exp);
  endtask

  initial begin
    reset_n           = 1'b0;
    irq               = '0;
    bus_if.addr       = '0;
    bus_if.data_write = '0;
    bus_if.uds        = 1'b0;
    bus_if.lds        = 1'b0;
    bus_if.rw         = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ipl", 16'(ipl_n), 16'h0007);
    check("rst_ack", 16'(bus_if.ack), 16'h0000);
    check("rst_data_read", bus_if.data_read, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);

    rd_check("rst_pending", 8'h00, 16'h0000);
    rd_check("rst_enable", 8'h02, 16'h0000);
    rd_check("rst_ctrl", 8'h04, 16'h0000);
    check("idle_ipl", 16'(ipl_n), 16'h0007);

    // Single edge on irq[2] -> level 3 exactly three edges later
    wr(8'h02, 16'h0005, 1'b1, 1'b1);
    wr(8'h04, 16'h0001, 1'b1, 1'b1);
    check("cfg_ipl", 16'(ipl_n), 16'h0007);
    irq[2] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    irq[2] = 1'b0;
    @(negedge clk);
    check("lat_k2_ipl", 16'(ipl_n), 16'h0007);
    @(negedge clk);
    check("lat_k3_ipl", 16'(ipl_n), 16'h0004);
    rd_check("pend_bit2", 8'h00, 16'h0004);
    rd_check("ctrl_lvl3", 8'h04, 16'h0301);

    // Two simultaneous edges, then clear in priority order
    irq = 7'b0000101;
    repeat (2) @(negedge clk);
    irq = '0;
    repeat (3) @(negedge clk);
    check("dual_ipl", 16'(ipl_n), 16'h0004);
    rd_check("dual_pend", 8'h00, 16'h0005);
    wr(8'h00, 16'h0004, 1'b1, 1'b1);
    check("w1c2_ipl", 16'(ipl_n), 16'h0006);
    wr(8'h00, 16'h0001, 1'b1, 1'b1);
    check("w1c0_ipl", 16'(ipl_n), 16'h0007);
    rd_check("w1c_pend", 8'h00, 16'h0000);

    // W1C lands on the same edge as a fresh rise on irq[1]: set wins
    wr(8'h02, 16'h0007, 1'b1, 1'b1);
    irq[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wr(8'h00, 16'h0002, 1'b1, 1'b1);
    check("race_ipl", 16'(ipl_n), 16'h0005);
    rd_check("race_pend", 8'h00, 16'h0002);
    wr(8'h00, 16'h0002, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check("held_ipl", 16'(ipl_n), 16'h0007);
    rd_check("held_pend", 8'h00, 16'h0000);

    // Byte lanes, unmapped addresses, addr[0] ignored
    wr(8'h02, 16'h12FF, 1'b0, 1'b1);
    rd_check("lds_enable", 8'h02, 16'h007F);
    wr(8'h02, 16'h0000, 1'b1, 1'b0);
    rd_check("uds_enable", 8'h02, 16'h007F);
    wr(8'h04, 16'h0000, 1'b1, 1'b0);
    rd_check("uds_ctrl", 8'h04, 16'h0001);
    wr(8'h0E, 16'hFFFF, 1'b1, 1'b1);
    rd_check("unmapped", 8'h0E, 16'h0000);
    rd_check("odd_addr", 8'h03, 16'h007F);
    check("lanes_ipl", 16'(ipl_n), 16'h0007);

`ifdef IRQ_LEVEL_MODE_EN
    wr(8'h06, 16'h0008, 1'b1, 1'b1);
    rd_check("mode_rd", 8'h06, 16'h0008);
    irq[3] = 1'b1;
    repeat (4) @(negedge clk);
    check("lvl_ipl", 16'(ipl_n), 16'h0003);
    wr(8'h00, 16'h0008, 1'b1, 1'b1);
    check("lvl_w1c_ipl", 16'(ipl_n), 16'h0003);
    rd_check("lvl_pend", 8'h00, 16'h0008);
    irq[3] = 1'b0;
    repeat (3) @(negedge clk);
    check("lvl_drop_ipl", 16'(ipl_n), 16'h0007);
`else
    wr(8'h06, 16'h00FF, 1'b1, 1'b1);
    rd_check("mode_absent", 8'h06, 16'h0000);
`endif

    // Strobe held for five cycles -> exactly one ack
    bus_if.addr = 8'h02;
    bus_if.rw   = 1'b1;
    bus_if.uds  = 1'b1;
    ack_cnt     = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.ack === 1'b1) ack_cnt++;
    end
    bus_if.uds = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus_if.ack === 1'b1) ack_cnt++;
    end
    check("hold_ack_cnt", 16'(ack_cnt), 16'h0001);
    check("hold_data", bus_if.data_read, 16'h007F);
    $display("RD addr=02 held uds 5 cycles acks=%0d", ack_cnt);

    // Reset in the middle of a transfer; strobe still up after release
    bus_if.addr = 8'h02;
    bus_if.lds  = 1'b1;
    @(negedge clk);
    check("mid_ack_pre", 16'(bus_if.ack), 16'h0001);
    #2 reset_n = 1'b0;
    #1;
    check("mid_ack_rst", 16'(bus_if.ack), 16'h0000);
    check("mid_data_rst", bus_if.data_read, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_ack_new", 16'(bus_if.ack), 16'h0001);
    check("mid_data_new", bus_if.data_read, 16'h0000);
    bus_if.lds = 1'b0;
    @(negedge clk);
    check("mid_ack_end", 16'(bus_if.ack), 16'h0000);
    $display("RD addr=02 across reset data=%04h", bus_if.data_read);
    rd_check("post_rst_enable", 8'h02, 16'h0000);
    check("post_rst_ipl", 16'(ipl_n), 16'h0007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
